// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - tone decoder defaults, class codes and window arithmetic
package tone_pkg;

    localparam int unsigned DEF_CLOCK_HZ      = 100_000_000;
    localparam int unsigned DEF_ITEM0_FREQ_HZ = 800;
    localparam int unsigned DEF_ITEM1_FREQ_HZ = 1000;
    localparam int unsigned DEF_ITEM2_FREQ_HZ = 1200;
    localparam int unsigned DEF_ITEM3_FREQ_HZ = 1400;
    localparam int unsigned DEF_ERROR_FREQ_HZ = 300;
    localparam int unsigned DEF_TOL_PCT       = 5;
    localparam int unsigned DEF_LOCK_HALVES   = 8;
    localparam int unsigned DEF_SILENCE_MS    = 4;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_ITEM0 = 3'd1,
        CLS_ITEM1 = 3'd2,
        CLS_ITEM2 = 3'd3,
        CLS_ITEM3 = 3'd4,
        CLS_ERR   = 3'd5
    } tone_class_t;

    // The generator toggles every divider+1 clocks, hence the +1.
    function automatic int unsigned half_period(input int unsigned clock_hz,
                                                input int unsigned freq_hz);
        return clock_hz / (2 * freq_hz) + 1;
    endfunction

    // 64-bit intermediate keeps h*(100+tol) from overflowing at slow tones.
    function automatic int unsigned window_lo(input int unsigned h, input int unsigned tol_pct);
        return 32'((64'(h) * 64'(100 - tol_pct)) / 64'd100);
    endfunction

    function automatic int unsigned window_hi(input int unsigned h, input int unsigned tol_pct);
        return 32'((64'(h) * 64'(100 + tol_pct)) / 64'd100);
    endfunction

    function automatic logic [1:0] item_code(input tone_class_t c);
        case (c)
            CLS_ITEM1: return 2'd1;
            CLS_ITEM2: return 2'd2;
            CLS_ITEM3: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - 2-flop synchroniser with registered any-edge strobe
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    // Resynchronise din, then strobe one cycle whenever the synced level changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta       <= 1'b0;
            sync       <= 1'b0;
            sync_d     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            meta       <= din;
            sync       <= meta;
            sync_d     <= sync;
            edge_pulse <= sync ^ sync_d;
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - half-period tone classifier with lock and end-of-tone reporting
module tone_decoder
    import tone_pkg::*;
#(
    parameter int unsigned CLOCK_HZ      = DEF_CLOCK_HZ,
    parameter int unsigned ITEM0_FREQ_HZ = DEF_ITEM0_FREQ_HZ,
    parameter int unsigned ITEM1_FREQ_HZ = DEF_ITEM1_FREQ_HZ,
    parameter int unsigned ITEM2_FREQ_HZ = DEF_ITEM2_FREQ_HZ,
    parameter int unsigned ITEM3_FREQ_HZ = DEF_ITEM3_FREQ_HZ,
    parameter int unsigned ERROR_FREQ_HZ = DEF_ERROR_FREQ_HZ,
    parameter int unsigned TOL_PCT       = DEF_TOL_PCT,
    parameter int unsigned LOCK_HALVES   = DEF_LOCK_HALVES,
    parameter int unsigned SILENCE_MS    = DEF_SILENCE_MS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        audio_in,
    output logic        tone_valid,
    output logic [1:0]  tone_item,
    output logic        tone_error,
    output logic        tone_done,
    output logic [15:0] tone_halves,
    output logic        busy
);

    localparam logic [31:0] H_ERR = half_period(CLOCK_HZ, ERROR_FREQ_HZ);
    localparam logic [31:0] H_I0  = half_period(CLOCK_HZ, ITEM0_FREQ_HZ);
    localparam logic [31:0] H_I1  = half_period(CLOCK_HZ, ITEM1_FREQ_HZ);
    localparam logic [31:0] H_I2  = half_period(CLOCK_HZ, ITEM2_FREQ_HZ);
    localparam logic [31:0] H_I3  = half_period(CLOCK_HZ, ITEM3_FREQ_HZ);

    localparam logic [31:0] ERR_LO = window_lo(H_ERR, TOL_PCT);
    localparam logic [31:0] ERR_HI = window_hi(H_ERR, TOL_PCT);
    localparam logic [31:0] I0_LO  = window_lo(H_I0, TOL_PCT);
    localparam logic [31:0] I0_HI  = window_hi(H_I0, TOL_PCT);
    localparam logic [31:0] I1_LO  = window_lo(H_I1, TOL_PCT);
    localparam logic [31:0] I1_HI  = window_hi(H_I1, TOL_PCT);
    localparam logic [31:0] I2_LO  = window_lo(H_I2, TOL_PCT);
    localparam logic [31:0] I2_HI  = window_hi(H_I2, TOL_PCT);
    localparam logic [31:0] I3_LO  = window_lo(H_I3, TOL_PCT);
    localparam logic [31:0] I3_HI  = window_hi(H_I3, TOL_PCT);

    localparam logic [31:0] SILENCE_CYCLES = 32'((CLOCK_HZ / 1000) * SILENCE_MS);
    localparam logic [15:0] LOCK_CNT       = 16'(LOCK_HALVES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic        edge_pulse;
    logic [31:0] hp_cnt;
    logic [1:0]  state;
    tone_class_t cls;
    tone_class_t cand;
    logic [15:0] match_cnt;
    logic        same;
    logic [15:0] acq_cnt;
    tone_class_t acq_cand;
    logic        silent;

    sync_edge_detect u_sync (
        .clk        (clk),
        .rst        (rst),
        .din        (audio_in),
        .edge_pulse (edge_pulse)
    );

    assign silent = (hp_cnt == SILENCE_CYCLES);
    assign busy   = (state != ST_IDLE);

    // Clocks since the last edge; restarts at 1 so an N-cycle half reads N at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_cnt <= 32'd0;
        end else if (edge_pulse) begin
            hp_cnt <= 32'd1;
        end else if (hp_cnt < SILENCE_CYCLES) begin
            hp_cnt <= hp_cnt + 32'd1;
        end
    end

    // Window lookup on the just-finished half; error tone has first claim.
    always_comb begin
        cls = CLS_NONE;
        if (hp_cnt >= ERR_LO && hp_cnt <= ERR_HI) begin
            cls = CLS_ERR;
        end else if (hp_cnt >= I0_LO && hp_cnt <= I0_HI) begin
            cls = CLS_ITEM0;
        end else if (hp_cnt >= I1_LO && hp_cnt <= I1_HI) begin
            cls = CLS_ITEM1;
        end else if (hp_cnt >= I2_LO && hp_cnt <= I2_HI) begin
            cls = CLS_ITEM2;
        end else if (hp_cnt >= I3_LO && hp_cnt <= I3_HI) begin
            cls = CLS_ITEM3;
        end
    end

    // Candidate tracking shared by acquisition and the restart out of lock.
    always_comb begin
        same = (cls != CLS_NONE) && (cls == cand);
        if (same) begin
            acq_cnt = match_cnt + 16'd1;
        end else if (cls != CLS_NONE) begin
            acq_cnt = 16'd1;
        end else begin
            acq_cnt = 16'd0;
        end
        acq_cand = (same || cls == CLS_NONE) ? cand : cls;
    end

    // Tone FSM; an edge always wins over a silence terminal count in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cand        <= CLS_NONE;
            match_cnt   <= 16'd0;
            tone_valid  <= 1'b0;
            tone_done   <= 1'b0;
            tone_item   <= 2'd0;
            tone_error  <= 1'b0;
            tone_halves <= 16'd0;
        end else begin
            tone_valid <= 1'b0;
            tone_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (edge_pulse) begin
                        state     <= ST_ACQUIRE;
                        cand      <= CLS_NONE;
                        match_cnt <= 16'd0;
                    end
                end
                ST_ACQUIRE: begin
                    if (edge_pulse) begin
                        match_cnt <= acq_cnt;
                        cand      <= acq_cand;
                        if (acq_cnt == LOCK_CNT) begin
                            state       <= ST_LOCKED;
                            tone_valid  <= 1'b1;
                            tone_item   <= item_code(acq_cand);
                            tone_error  <= (acq_cand == CLS_ERR);
                            tone_halves <= LOCK_CNT;
                        end
                    end else if (silent) begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (edge_pulse) begin
                        if (same) begin
                            if (tone_halves != 16'hFFFF) begin
                                tone_halves <= tone_halves + 16'd1;
                            end
                        end else begin
                            tone_done <= 1'b1;
                            state     <= ST_ACQUIRE;
                            match_cnt <= acq_cnt;
                            cand      <= acq_cand;
                        end
                    end else if (silent) begin
                        tone_done <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
